// File: rtl/memory_bank_pkg.sv
// Shared types and helpers for the memory_bank storage block.
package memory_bank_pkg;

   // Clear sequencer states
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } bank_state_t;

   // Address width needed to index a bank of the given depth
   function automatic int addr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/memory_bank_mem_word.sv
// One storage word: WIDTH-bit register with async reset and load enable.
module mem_word
   import memory_bank_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture d when loaded; reset returns the word to zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/memory_bank.sv
// Parametrised storage bank: one write port, one registered read port with
// valid pulse, and a self-timed sequencer that zeroes every word.
module memory_bank
   import memory_bank_pkg::*;
#(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 4,
   localparam int AW    = addr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data,
   input  logic             store,
   input  logic [AW-1:0]    addr,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] memory,
   output logic             rd_valid,
   input  logic             clear,
   output logic             busy,
   output logic             store_drop
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   bank_state_t      state;
   bank_state_t      state_next;
   logic [AW-1:0]    cnt;
   logic [AW-1:0]    cnt_next;
   logic             idle;
   logic             addr_ok;
   logic             rd_addr_ok;
   logic             write_ok;
   logic             rd_ok;
   logic [WIDTH-1:0] rd_word;
   logic [WIDTH-1:0] word_q [DEPTH];

   assign idle       = (state == ST_IDLE);
   assign busy       = (state == ST_CLEAR);
   assign addr_ok    = int'(addr) < DEPTH;
   assign rd_addr_ok = int'(rd_addr) < DEPTH;
   // A store only lands in IDLE and loses to a same-cycle clear request
   assign write_ok   = idle && store && !clear && addr_ok;
   assign rd_ok      = idle && rd_en;

   // Storage words: loaded by the write decode or zeroed by the sequencer
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      logic wr_hit;
      logic clr_hit;
      assign wr_hit  = write_ok && (addr == AW'(gi));
      assign clr_hit = busy && (cnt == AW'(gi));
      mem_word #(.WIDTH(WIDTH)) u_word (
         .clk   (clk),
         .reset (reset),
         .load  (wr_hit || clr_hit),
         .d     (clr_hit ? '0 : data),
         .q     (word_q[gi])
      );
   end

   // Clear sequencer next state: walk cnt from 0 to DEPTH-1, then back to IDLE
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_IDLE: begin
            if (clear) begin
               state_next = ST_CLEAR;
               cnt_next   = '0;
            end
         end
         ST_CLEAR: begin
            if (cnt == LAST) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Read mux with write-first bypass; out-of-range addresses read as zero
   always_comb begin
      rd_word = '0;
      if (rd_addr_ok) begin
         if (write_ok && (addr == rd_addr))
            rd_word = data;
         else
            rd_word = word_q[rd_addr];
      end
   end

   // Sequencer state, read output register and drop pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         memory     <= '0;
         rd_valid   <= 1'b0;
         store_drop <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         rd_valid   <= rd_ok;
         store_drop <= store && (busy || clear);
         if (rd_ok)
            memory <= rd_word;
      end
   end

endmodule

// File: tb/tb_memory_bank.sv
// Directed self-checking bench for memory_bank (DEPTH=4 and DEPTH=5 builds).
module tb_memory_bank;

   logic       clk = 1'b0;
   logic       reset;

   // DEPTH=4 instance signals
   logic [7:0] data;
   logic       store;
   logic [1:0] addr;
   logic       rd_en;
   logic [1:0] rd_addr;
   logic [7:0] memory;
   logic       rd_valid;
   logic       clear;
   logic       busy;
   logic       store_drop;

   // DEPTH=5 instance signals
   logic [7:0] data5;
   logic       store5;
   logic [2:0] addr5;
   logic       rd_en5;
   logic [2:0] rd_addr5;
   logic [7:0] memory5;
   logic       rd_valid5;
   logic       clear5;
   logic       busy5;
   logic       store_drop5;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   memory_bank #(.WIDTH(8), .DEPTH(4)) u4 (
      .clk        (clk),
      .reset      (reset),
      .data       (data),
      .store      (store),
      .addr       (addr),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .memory     (memory),
      .rd_valid   (rd_valid),
      .clear      (clear),
      .busy       (busy),
      .store_drop (store_drop)
   );

   memory_bank #(.WIDTH(8), .DEPTH(5)) u5 (
      .clk        (clk),
      .reset      (reset),
      .data       (data5),
      .store      (store5),
      .addr       (addr5),
      .rd_en      (rd_en5),
      .rd_addr    (rd_addr5),
      .memory     (memory5),
      .rd_valid   (rd_valid5),
      .clear      (clear5),
      .busy       (busy5),
      .store_drop (store_drop5)
   );

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %0h (t=%0t)", tag, got, $time);
      end
   endtask

   // Advance one clock and sample just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      data = '0; store = 0; addr = '0; rd_en = 0; rd_addr = '0; clear = 0;
      data5 = '0; store5 = 0; addr5 = '0; rd_en5 = 0; rd_addr5 = '0; clear5 = 0;
      tick(); tick();
      check_vec("rst_memory", memory, 0);
      check_vec("rst_valid", rd_valid, 0);
      check_vec("rst_busy", busy, 0);
      check_vec("rst_drop", store_drop, 0);
      reset = 1'b0;

      // Write then read back with latency 1
      store = 1; addr = 2'd1; data = 8'hA5; tick();
      check_vec("wr1_drop", store_drop, 0);
      addr = 2'd2; data = 8'h3C; rd_en = 1; rd_addr = 2'd1; tick();
      check_vec("rd1_data", memory, 8'hA5);
      check_vec("rd1_valid", rd_valid, 1);
      store = 0; rd_addr = 2'd2; tick();
      check_vec("rd2_data", memory, 8'h3C);
      rd_en = 0; tick();
      check_vec("idle_valid", rd_valid, 0);
      check_vec("idle_hold", memory, 8'h3C);

      // Write-first bypass
      store = 1; addr = 2'd3; data = 8'h77; rd_en = 1; rd_addr = 2'd3; tick();
      check_vec("bypass_data", memory, 8'h77);
      check_vec("bypass_valid", rd_valid, 1);
      store = 0; rd_addr = 2'd0; tick();
      check_vec("rd0_unwritten", memory, 8'h00);
      rd_addr = 2'd1; tick();
      check_vec("rd1_again", memory, 8'hA5);

      // Asynchronous reset mid-cycle
      rd_en = 0; #3; reset = 1; #1;
      check_vec("async_rst_mem", memory, 0);
      check_vec("async_rst_valid", rd_valid, 0);
      tick(); reset = 0;
      rd_en = 1;
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i); tick();
         check_vec($sformatf("post_rst_rd%0d", i), memory, 0);
         check_vec($sformatf("post_rst_v%0d", i), rd_valid, 1);
      end
      rd_en = 0;

      // Fill then clear
      for (int i = 0; i < 4; i++) begin
         store = 1; addr = 2'(i); data = 8'(8'h11 * (i + 1));
         rd_en = (i == 3); rd_addr = 2'd3; tick();
      end
      check_vec("fill_rd3", memory, 8'h44);
      store = 0; rd_en = 0; clear = 1; tick();
      check_vec("clr_busy0", busy, 1);
      clear = 0; store = 1; addr = 2'd0; data = 8'h99; tick();
      check_vec("clr_busy1", busy, 1);
      check_vec("clr_drop", store_drop, 1);
      store = 0; rd_en = 1; rd_addr = 2'd1; clear = 1; tick();
      check_vec("clr_busy2", busy, 1);
      check_vec("clr_drop_end", store_drop, 0);
      check_vec("clr_rd_ignored", rd_valid, 0);
      check_vec("clr_mem_hold", memory, 8'h44);
      rd_en = 0; clear = 0; tick();
      check_vec("clr_busy3", busy, 1);
      tick();
      check_vec("clr_done", busy, 0);
      rd_en = 1;
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i); tick();
         check_vec($sformatf("clr_rd%0d", i), memory, 0);
      end
      rd_en = 0;

      // Clear and store collide: clear wins, same-cycle read sees old word
      store = 1; addr = 2'd2; data = 8'h66; tick();
      data = 8'h5A; clear = 1; rd_en = 1; rd_addr = 2'd2; tick();
      check_vec("coll_drop", store_drop, 1);
      check_vec("coll_rd_old", memory, 8'h66);
      check_vec("coll_busy", busy, 1);
      store = 0; clear = 0; rd_en = 0;
      tick(); tick(); tick(); tick();
      check_vec("coll_done", busy, 0);

      // Reset aborts an in-progress clear
      clear = 1; tick();
      clear = 0; tick();
      check_vec("abort_busy_pre", busy, 1);
      #3; reset = 1; #1;
      check_vec("abort_busy_now", busy, 0);
      tick(); reset = 0;
      check_vec("abort_idle", busy, 0);
      store = 1; addr = 2'd1; data = 8'hC3; rd_en = 1; rd_addr = 2'd1; tick();
      check_vec("abort_wr_drop", store_drop, 0);
      check_vec("abort_wr_rd", memory, 8'hC3);
      store = 0; rd_en = 0;

      // DEPTH=5: out-of-range accesses and a 5-cycle clear
      store5 = 1; addr5 = 3'd4; data5 = 8'h12; tick();
      addr5 = 3'd6; data5 = 8'hFF; tick();
      check_vec("d5_oob_drop", store_drop5, 0);
      store5 = 0; rd_en5 = 1; rd_addr5 = 3'd6; tick();
      check_vec("d5_oob_rd", memory5, 0);
      check_vec("d5_oob_valid", rd_valid5, 1);
      rd_addr5 = 3'd4; tick();
      check_vec("d5_rd4", memory5, 8'h12);
      rd_addr5 = 3'd2; tick();
      check_vec("d5_rd2_untouched", memory5, 0);
      rd_en5 = 0; clear5 = 1; tick();
      clear5 = 0;
      n = 0;
      for (int k = 0; k < 20 && busy5; k++) begin
         n++;
         tick();
      end
      check_vec("d5_clear_len", 32'(n), 5);
      rd_en5 = 1; rd_addr5 = 3'd4; tick();
      check_vec("d5_clr_rd4", memory5, 0);
      rd_en5 = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
